// File: rtl/sdrc_app_arb_if.sv
// Application request bus between the arbiter and sdrc_core.
//   master : arbiter side, drives request/write-data fields, receives core strobes
//   slave  : core side, receives request/write-data fields, drives strobes/read data
// Signals:
//   app_req / app_req_addr / app_req_len / app_req_wr_n : request and its fields
//   app_req_ack     : core accepted the request
//   app_wr_data / app_wr_en_n : write data and active-low byte enables
//   app_wr_next_req : core consumed one write beat
//   app_rd_valid / app_rd_data : read beat
//   app_last_rd / app_last_wr  : final beat of the current burst
interface sdrc_app_arb_if #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9
);
  logic              app_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [bl-1:0]     app_req_len;
  logic              app_req_wr_n;
  logic              app_req_ack;
  logic [dw-1:0]     app_wr_data;
  logic [dw/8-1:0]   app_wr_en_n;
  logic              app_wr_next_req;
  logic              app_rd_valid;
  logic [dw-1:0]     app_rd_data;
  logic              app_last_rd;
  logic              app_last_wr;

  modport master (
    output app_req, app_req_addr, app_req_len, app_req_wr_n,
    output app_wr_data, app_wr_en_n,
    input  app_req_ack, app_wr_next_req, app_rd_valid, app_rd_data,
    input  app_last_rd, app_last_wr
  );

  modport slave (
    input  app_req, app_req_addr, app_req_len, app_req_wr_n,
    input  app_wr_data, app_wr_en_n,
    output app_req_ack, app_wr_next_req, app_rd_valid, app_rd_data,
    output app_last_rd, app_last_wr
  );
endinterface

// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing the sdrc_core application request interface
// among NP requesters. One requester owns the bus from grant until the last
// write or read beat of its burst; data handshakes are steered only to it.
// Ports:
//   sdram_clk, sdram_resetn : controller clock, async active-low reset
//   sdr_init_done           : no new grant while low
//   p_req/p_req_addr/p_req_len/p_req_wr_n : per-port request fields (port i
//                             at slice i of each packed vector)
//   p_req_ack               : per-port request accepted
//   p_wr_data/p_wr_en_n     : per-port write data / active-low byte enables
//   p_wr_next/p_last_wr     : per-port write advance / last write beat
//   p_rd_valid/p_last_rd    : per-port read valid / last read beat
//   p_rd_data               : read data broadcast to all ports
//   app                     : core-side application bus (master modport)
//   arb_grant               : one-hot current owner, 0 when idle
//   arb_busy                : transaction in progress
module sdrc_app_arb #(
  parameter int NP     = 4,
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 sdr_init_done,
  input  logic [NP-1:0]        p_req,
  input  logic [NP*APP_AW-1:0] p_req_addr,
  input  logic [NP*bl-1:0]     p_req_len,
  input  logic [NP-1:0]        p_req_wr_n,
  output logic [NP-1:0]        p_req_ack,
  input  logic [NP*dw-1:0]     p_wr_data,
  input  logic [NP*dw/8-1:0]   p_wr_en_n,
  output logic [NP-1:0]        p_wr_next,
  output logic [NP-1:0]        p_rd_valid,
  output logic [NP-1:0]        p_last_rd,
  output logic [NP-1:0]        p_last_wr,
  output logic [dw-1:0]        p_rd_data,
  sdrc_app_arb_if.master       app,
  output logic [NP-1:0]        arb_grant,
  output logic                 arb_busy
);

  localparam int BW = dw / 8;
  localparam int PW = $clog2(NP);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;        // round-robin priority pointer
  logic [PW-1:0] gidx;       // index of the granted port
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] cand;
  logic          sel_found;
  logic          done;       // last beat of the owner's burst this cycle

  // First requesting port at or above the pointer, wrapping modulo NP.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      cand = PW'((32'(ptr) + i) % NP);
      if (!sel_found && p_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) state <= IDLE;
    else               state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (sdr_init_done && sel_found) state_nxt = REQ;
      end
      REQ: begin
        if (app.app_req_ack) state_nxt = p_req_wr_n[gidx] ? RDATA : WDATA;
      end
      WDATA: begin
        if (app.app_wr_next_req && app.app_last_wr) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      RDATA: begin
        if (app.app_rd_valid && app.app_last_rd) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and pointer registers. The grant is loaded only on the IDLE->REQ
  // transition, so a completed owner always leaves at least one IDLE cycle.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      arb_grant <= '0;
      gidx      <= '0;
      ptr       <= '0;
    end else if (state == IDLE && state_nxt == REQ) begin
      arb_grant <= {{(NP-1){1'b0}}, 1'b1} << sel_idx;
      gidx      <= sel_idx;
    end else if (done) begin
      arb_grant <= '0;
      ptr       <= (gidx == PW'(NP - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Output logic: request fields follow the owner; strobes reach only the
  // owner and only in the phase matching its transfer direction.
  always_comb begin
    app.app_req      = 1'b0;
    app.app_req_addr = '0;
    app.app_req_len  = '0;
    app.app_req_wr_n = 1'b0;
    app.app_wr_data  = '0;
    app.app_wr_en_n  = '1;
    p_req_ack        = '0;
    p_wr_next        = '0;
    p_last_wr        = '0;
    p_rd_valid       = '0;
    p_last_rd        = '0;
    p_rd_data        = app.app_rd_data;
    arb_busy         = (state != IDLE);

    if (state != IDLE) begin
      app.app_req_addr = p_req_addr[gidx*APP_AW +: APP_AW];
      app.app_req_len  = p_req_len[gidx*bl +: bl];
      app.app_req_wr_n = p_req_wr_n[gidx];
    end

    case (state)
      REQ: begin
        app.app_req     = 1'b1;
        p_req_ack[gidx] = app.app_req_ack;
      end
      WDATA: begin
        app.app_wr_data = p_wr_data[gidx*dw +: dw];
        app.app_wr_en_n = p_wr_en_n[gidx*BW +: BW];
        p_wr_next[gidx] = app.app_wr_next_req;
        p_last_wr[gidx] = app.app_last_wr;
      end
      RDATA: begin
        p_rd_valid[gidx] = app.app_rd_valid;
        p_last_rd[gidx]  = app.app_last_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdrc_app_arb.sv
module tb_sdrc_app_arb;
  localparam int NP     = 4;
  localparam int APP_AW = 26;
  localparam int DW     = 32;
  localparam int BL     = 9;
  localparam int BW     = DW / 8;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 init;
  logic [NP-1:0]        p_req;
  logic [NP*APP_AW-1:0] p_req_addr;
  logic [NP*BL-1:0]     p_req_len;
  logic [NP-1:0]        p_req_wr_n;
  logic [NP-1:0]        p_req_ack;
  logic [NP*DW-1:0]     p_wr_data;
  logic [NP*BW-1:0]     p_wr_en_n;
  logic [NP-1:0]        p_wr_next, p_rd_valid, p_last_rd, p_last_wr;
  logic [DW-1:0]        p_rd_data;
  logic [NP-1:0]        arb_grant;
  logic                 arb_busy;

  sdrc_app_arb_if #(.APP_AW(APP_AW), .dw(DW), .bl(BL)) app_if ();

  sdrc_app_arb #(.NP(NP), .APP_AW(APP_AW), .dw(DW), .bl(BL)) dut (
    .sdram_clk    (clk),
    .sdram_resetn (resetn),
    .sdr_init_done(init),
    .p_req        (p_req),
    .p_req_addr   (p_req_addr),
    .p_req_len    (p_req_len),
    .p_req_wr_n   (p_req_wr_n),
    .p_req_ack    (p_req_ack),
    .p_wr_data    (p_wr_data),
    .p_wr_en_n    (p_wr_en_n),
    .p_wr_next    (p_wr_next),
    .p_rd_valid   (p_rd_valid),
    .p_last_rd    (p_last_rd),
    .p_last_wr    (p_last_wr),
    .p_rd_data    (p_rd_data),
    .app          (app_if),
    .arb_grant    (arb_grant),
    .arb_busy     (arb_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = port holding the bus (-1 none); accepted = core has taken its
  // request; is_wr = accepted transfer is a write; rr = next preferred port.
  int            owner    = -1;
  bit            accepted = 1'b0;
  bit            is_wr    = 1'b0;
  int            rr       = 0;
  logic [NP-1:0] ack_seen = '0;

  logic [NP-1:0] e_gnt, e_ack, e_nxt, e_lw, e_rv, e_lr;
  logic [DW-1:0] e_wd;
  logic [BW-1:0] e_en;
  bit            ph_req, ph_wr, ph_rd;

  always @(negedge clk) begin
    if (!resetn) begin
      owner = -1; accepted = 1'b0; rr = 0; ack_seen = '0;
      check("rst_grant", arb_grant, 0);
      check("rst_app_req", app_if.app_req, 0);
      check("rst_busy", arb_busy, 0);
      check("rst_rd_valid", p_rd_valid, 0);
      check("rst_wr_en_n", app_if.app_wr_en_n, 4'hF);
    end else begin
      ph_req = (owner >= 0) && !accepted;
      ph_wr  = (owner >= 0) && accepted && is_wr;
      ph_rd  = (owner >= 0) && accepted && !is_wr;
      e_gnt = '0; e_ack = '0; e_nxt = '0; e_lw = '0; e_rv = '0; e_lr = '0;
      e_wd  = '0; e_en  = '1;
      if (owner >= 0) e_gnt[owner] = 1'b1;
      if (ph_req) e_ack[owner] = app_if.app_req_ack;
      if (ph_wr) begin
        e_nxt[owner] = app_if.app_wr_next_req;
        e_lw[owner]  = app_if.app_last_wr;
        e_wd         = p_wr_data[owner*DW +: DW];
        e_en         = p_wr_en_n[owner*BW +: BW];
      end
      if (ph_rd) begin
        e_rv[owner] = app_if.app_rd_valid;
        e_lr[owner] = app_if.app_last_rd;
      end
      check("grant", arb_grant, e_gnt);
      check("busy", arb_busy, owner >= 0);
      check("app_req", app_if.app_req, ph_req);
      check("req_ack", p_req_ack, e_ack);
      check("wr_next", p_wr_next, e_nxt);
      check("last_wr", p_last_wr, e_lw);
      check("rd_valid", p_rd_valid, e_rv);
      check("last_rd", p_last_rd, e_lr);
      check("rd_data", p_rd_data, app_if.app_rd_data);
      check("wr_data", app_if.app_wr_data, e_wd);
      check("wr_en_n", app_if.app_wr_en_n, e_en);
      if (ph_req) begin
        check("req_addr", app_if.app_req_addr, p_req_addr[owner*APP_AW +: APP_AW]);
        check("req_len", app_if.app_req_len, p_req_len[owner*BL +: BL]);
        check("req_wr_n", app_if.app_req_wr_n, p_req_wr_n[owner]);
      end
      ack_seen = p_req_ack;
      // advance to the next cycle
      if (owner < 0) begin
        if (init) begin
          for (int k = 0; k < NP; k++) begin
            if (owner < 0 && p_req[(rr + k) % NP]) owner = (rr + k) % NP;
          end
          accepted = 1'b0;
        end
      end else if (!accepted) begin
        if (app_if.app_req_ack) begin
          accepted = 1'b1;
          is_wr    = !p_req_wr_n[owner];
        end
      end else if (is_wr ? (app_if.app_wr_next_req && app_if.app_last_wr)
                         : (app_if.app_rd_valid && app_if.app_last_rd)) begin
        rr    = (owner + 1) % NP;
        owner = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    app_if.app_req_ack     = 1'b0;
    app_if.app_wr_next_req = 1'b0;
    app_if.app_rd_valid    = 1'b0;
    app_if.app_rd_data     = '0;
    app_if.app_last_rd     = 1'b0;
    app_if.app_last_wr     = 1'b0;
  endtask

  logic [NP-1:0] pend = '0;

  task automatic rand_cycle();
    for (int i = 0; i < NP; i++) begin
      if (pend[i]) begin
        if (ack_seen[i]) begin
          pend[i]  = 1'b0;
          p_req[i] = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        pend[i]       = 1'b1;
        p_req[i]      = 1'b1;
        p_req_addr[i*APP_AW +: APP_AW] = APP_AW'($urandom);
        p_req_len[i*BL +: BL]          = BL'($urandom);
        p_req_wr_n[i] = 1'($urandom);
      end
      p_wr_data[i*DW +: DW] = $urandom;
      p_wr_en_n[i*BW +: BW] = BW'($urandom);
    end
    init                   = ($urandom_range(0, 19) != 0);
    app_if.app_req_ack     = ($urandom_range(0, 2) == 0);
    app_if.app_wr_next_req = 1'($urandom);
    app_if.app_last_wr     = ($urandom_range(0, 3) == 0);
    app_if.app_rd_valid    = 1'($urandom);
    app_if.app_last_rd     = ($urandom_range(0, 3) == 0);
    app_if.app_rd_data     = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    resetn = 1'b0; init = 1'b0;
    p_req = '1; p_req_wr_n = '1; p_wr_data = '0; p_wr_en_n = '1;
    for (int i = 0; i < NP; i++) begin
      p_req_addr[i*APP_AW +: APP_AW] = APP_AW'(32'h100 + i);
      p_req_len[i*BL +: BL]          = BL'(i + 1);
    end
    core_idle();

    // Requests pending but controller not initialised
    repeat (2) tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("t1_no_app_req", app_if.app_req, 0);
    check("t1_no_grant", arb_grant, 0);
    init = 1'b1;
    tick();
    check("t1_grant", arb_grant, 4'b0001);
    check("t1_app_req", app_if.app_req, 1);
    check("t1_addr", app_if.app_req_addr, 26'h100);
    check("t1_len", app_if.app_req_len, 9'd1);
    app_if.app_req_ack = 1'b1;
    #1;
    check("t1_ack", p_req_ack, 4'b0001);
    tick();
    app_if.app_req_ack = 1'b0;
    p_req = '0;
    app_if.app_rd_valid = 1'b1; app_if.app_last_rd = 1'b1;
    app_if.app_rd_data = 32'hDEADBEEF;
    #1;
    check("t1_rd_valid", p_rd_valid, 4'b0001);
    check("t1_last_rd", p_last_rd, 4'b0001);
    check("t1_rd_data", p_rd_data, 32'hDEADBEEF);
    tick();
    core_idle();
    check("t1_idle", arb_busy, 0);
    // stray read strobe while idle
    app_if.app_rd_valid = 1'b1;
    #1;
    check("t5_idle_rd_valid", p_rd_valid, 0);
    app_if.app_rd_valid = 1'b0;

    // Port 2 write, 4 beats, with a stray read strobe during the data phase
    p_req = 4'b0100; p_req_wr_n[2] = 1'b0;
    p_req_addr[2*APP_AW +: APP_AW] = 26'h2AA;
    p_req_len[2*BL +: BL] = 9'd4;
    tick();
    check("t2_grant", arb_grant, 4'b0100);
    app_if.app_req_ack = 1'b1;
    #1;
    check("t2_ack", p_req_ack, 4'b0100);
    tick();
    app_if.app_req_ack = 1'b0;
    p_req = '0;
    for (int b = 0; b < 4; b++) begin
      p_wr_data[95:64] = 32'hA000_0000 + 32'(b);
      p_wr_en_n[11:8]  = 4'(b);
      app_if.app_wr_next_req = 1'b1;
      app_if.app_last_wr = (b == 3);
      app_if.app_rd_valid = 1'b1;
      #1;
      check("t2_wr_next", p_wr_next, 4'b0100);
      check("t2_wr_data", app_if.app_wr_data, 32'hA000_0000 + 32'(b));
      check("t2_wr_en_n", app_if.app_wr_en_n, 4'(b));
      check("t2_last_wr", p_last_wr, (b == 3) ? 4'b0100 : 4'b0000);
      check("t5_wdata_rd_valid", p_rd_valid, 0);
      tick();
    end
    core_idle();
    check("t2_done_grant", arb_grant, 0);
    check("t2_done_en_n", app_if.app_wr_en_n, 4'hF);
    // pointer now at 3: with ports 0 and 3 requesting, 3 wins
    p_req = 4'b1001;
    tick();
    check("t2_ptr", arb_grant, 4'b1000);
    app_if.app_req_ack = 1'b1;
    tick();
    app_if.app_req_ack = 1'b0;
    p_req = '0;
    app_if.app_rd_valid = 1'b1; app_if.app_last_rd = 1'b1;
    tick();
    core_idle();

    // Port 1 read, acknowledge delayed by 5 cycles
    p_req = 4'b0010; p_req_wr_n[1] = 1'b1;
    p_req_addr[1*APP_AW +: APP_AW] = 26'h1234;
    p_req_len[1*BL +: BL] = 9'd8;
    tick();
    check("t4_grant", arb_grant, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      check("t4_app_req_held", app_if.app_req, 1);
      check("t4_addr_stable", app_if.app_req_addr, 26'h1234);
      check("t4_no_ack", p_req_ack, 0);
      tick();
    end
    app_if.app_req_ack = 1'b1;
    #1;
    check("t4_ack", p_req_ack, 4'b0010);
    tick();
    app_if.app_req_ack = 1'b0;
    p_req = '0;
    check("t4_req_drop", app_if.app_req, 0);

    // Reset in the middle of the read burst
    app_if.app_rd_valid = 1'b1;
    tick();
    #1;
    check("t6_beat2", p_rd_valid, 4'b0010);
    p_req = 4'b1010;
    resetn = 1'b0;
    #1;
    check("t6_rst_grant", arb_grant, 0);
    check("t6_rst_app_req", app_if.app_req, 0);
    check("t6_rst_busy", arb_busy, 0);
    check("t6_rst_rd_valid", p_rd_valid, 0);
    tick();
    resetn = 1'b1;
    core_idle();
    tick();
    check("t6_first_grant", arb_grant, 4'b0010);

    // Randomised traffic against the model
    p_req = '0;
    pend  = '0;
    for (int n = 0; n < 4000; n++) begin
      rand_cycle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
